regfile_write_arbiter: RTL and testbench

Owns the single register-file write port (write enable, write address, write data) and shares it between three requesters: core writeback, the t0 trigger source and a debug/loader write channel using a valid/ready handshake. After every reset it first runs a clear sequence that zeroes x1..x31. It enforces the x0 write suppression and has a starvation guard so debug writes always complete. It sits between the writeback stage and the register file write port.

---
 rtl/regfile_write_arbiter_if.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bundle: core writeback, t0 trigger, debug valid/ready in; registered rf_* write, core_stall, clear_busy out.
// The master modport drives the requests; the slave modport belongs to the arbiter.
interface regfile_write_arbiter_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic                     core_we;
  logic [ADDRESS_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0]    core_data;
  logic                     trigger;
  logic                     dbg_valid;
  logic [ADDRESS_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0]    dbg_data;
  logic                     dbg_ready;
  logic                     rf_we;
  logic [ADDRESS_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0]    rf_wd;
  logic                     core_stall;
  logic                     clear_busy;

  modport master (
    output core_we, core_addr, core_data, trigger, dbg_valid, dbg_addr, dbg_data,
    input  dbg_ready, rf_we, rf_addr, rf_wd, core_stall, clear_busy
  );

  modport slave (
    input  core_we, core_addr, core_data, trigger, dbg_valid, dbg_addr, dbg_data,
    output dbg_ready, rf_we, rf_addr, rf_wd, core_stall, clear_busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port (core > trigger > debug) and zeroes x1..x31 after every reset; grant-to-rf_* latency 1 cycle.
// Debug is backpressured by dbg_ready; the core is held by core_stall during clear and when debug has been blocked STARVE_LIMIT cycles.
module regfile_write_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int TRIG_REG      = 5,
  parameter int STARVE_LIMIT  = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  regfile_write_arbiter_if.slave rf_if
);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0]      STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                     trig_pend_q, trig_pend_d;
  logic [STARVE_W-1:0]      starve_q, starve_d;
  logic                     grant;
  logic                     we_d;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0]    wd_d;
  logic                     busy_d;
  logic                     stall_d;
  logic                     dbg_ready_c;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    trig_pend_d = trig_pend_q;
    starve_d    = starve_q;
    grant       = 1'b0;
    addr_d      = '0;
    wd_d        = '0;
    dbg_ready_c = 1'b0;

    case (state_q)
      CLEAR: begin
        // core_we is ignored here; triggers are only remembered
        grant       = 1'b1;
        addr_d      = clr_cnt_q;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        trig_pend_d = trig_pend_q | rf_if.trigger;
        if (clr_cnt_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        if (rf_if.core_we) begin
          grant       = 1'b1;
          addr_d      = rf_if.core_addr;
          wd_d        = rf_if.core_data;
          trig_pend_d = trig_pend_q | rf_if.trigger;
        end else if (trig_pend_q || rf_if.trigger) begin
          grant       = 1'b1;
          addr_d      = ADDRESS_WIDTH'(TRIG_REG);
          wd_d        = DATA_WIDTH'(1);
          trig_pend_d = 1'b0;
        end else if (rf_if.dbg_valid) begin
          grant       = 1'b1;
          dbg_ready_c = 1'b1;
          addr_d      = rf_if.dbg_addr;
          wd_d        = rf_if.dbg_data;
        end
        // Saturating count of consecutive blocked debug cycles
        if (rf_if.dbg_valid && !dbg_ready_c)
          starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
        else
          starve_d = '0;
      end
      default: state_d = CLEAR;
    endcase

    we_d    = grant && (addr_d != '0);
    busy_d  = (state_d == CLEAR);
    stall_d = busy_d || (starve_d == STARVE_MAX);
  end

  assign rf_if.dbg_ready = dbg_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= CLEAR;
      clr_cnt_q        <= ADDRESS_WIDTH'(1);
      trig_pend_q      <= 1'b0;
      starve_q         <= '0;
      rf_if.rf_we      <= 1'b0;
      rf_if.rf_addr    <= '0;
      rf_if.rf_wd      <= '0;
      rf_if.core_stall <= 1'b1;
      rf_if.clear_busy <= 1'b1;
    end else begin
      state_q          <= state_d;
      clr_cnt_q        <= clr_cnt_d;
      trig_pend_q      <= trig_pend_d;
      starve_q         <= starve_d;
      rf_if.rf_we      <= we_d;
      rf_if.rf_addr    <= addr_d;
      rf_if.rf_wd      <= wd_d;
      rf_if.core_stall <= stall_d;
      rf_if.clear_busy <= busy_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, multi-cycle corner sequences, and random traffic against a reference model.
module tb_regfile_write_arbiter;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int TRIG = 5;
  localparam int LIM  = 8;
  localparam int NREG = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  regfile_write_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_write_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TRIG_REG(TRIG), .STARVE_LIMIT(LIM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rf_if(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cdata;
    logic          trig;
    logic          dv;
    logic [AW-1:0] daddr;
    logic [DW-1:0] ddata;
    logic          e_rdy;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.core_we   = 1'b0;
    bus.core_addr = '0;
    bus.core_data = '0;
    bus.trigger   = 1'b0;
    bus.dbg_valid = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_data  = '0;
  endtask

  function automatic vec_t mk(input int cwe, input int caddr, input logic [DW-1:0] cdata,
                              input int trig, input int dv, input int daddr,
                              input logic [DW-1:0] ddata, input int e_rdy, input int e_we,
                              input int e_addr, input logic [DW-1:0] e_wd);
    vec_t v;
    v.cwe    = 1'(cwe);
    v.caddr  = AW'(caddr);
    v.cdata  = cdata;
    v.trig   = 1'(trig);
    v.dv     = 1'(dv);
    v.daddr  = AW'(daddr);
    v.ddata  = ddata;
    v.e_rdy  = 1'(e_rdy);
    v.e_we   = 1'(e_we);
    v.e_addr = AW'(e_addr);
    v.e_wd   = e_wd;
    return v;
  endfunction

  // Walks the 31 clear cycles; optional triggers and ignored core/debug requests are mixed in.
  task automatic check_clear(input bit with_noise);
    for (int i = 1; i < NREG; i++) begin
      idle();
      if (with_noise) begin
        bus.trigger = (i == 3) || (i == 10) || (i == 20);
        if (i == 7) begin
          bus.core_we   = 1'b1;
          bus.core_addr = AW'(9);
          bus.core_data = 32'hFF;
        end
        if (i == 12) begin
          bus.dbg_valid = 1'b1;
          bus.dbg_addr  = AW'(4);
          bus.dbg_data  = 32'h12;
          #1 chk("clear_dbg_ready", bus.dbg_ready, 0);
        end
      end
      step();
      chk("clear_we", bus.rf_we, 1);
      chk("clear_addr", bus.rf_addr, i);
      chk("clear_wd", bus.rf_wd, 0);
      chk("clear_busy", bus.clear_busy, (i < NREG - 1));
      chk("clear_stall", bus.core_stall, (i < NREG - 1));
    end
    idle();
  endtask

  logic [DW-1:0] mrf[NREG];
  logic [DW-1:0] drf[NREG];

  initial begin
    idle();
    rst_n = 1'b0;

    // Reset state, with a debug request that must not be accepted
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = AW'(3);
    #12;
    chk("rst_we", bus.rf_we, 0);
    chk("rst_addr", bus.rf_addr, 0);
    chk("rst_wd", bus.rf_wd, 0);
    chk("rst_busy", bus.clear_busy, 1);
    chk("rst_stall", bus.core_stall, 1);
    chk("rst_dbg_ready", bus.dbg_ready, 0);
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Clear with three trigger pulses -> one t0 write on the first RUN cycle
    check_clear(1'b1);
    step();
    chk("trig_merge_we", bus.rf_we, 1);
    chk("trig_merge_wr", {bus.rf_addr, bus.rf_wd}, {AW'(TRIG), 32'd1});
    chk("run_busy", bus.clear_busy, 0);
    chk("run_stall", bus.core_stall, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("trig_merge_once", bus.rf_we, 0);
    end

    vecs[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0, 0,        0, 1, 3, 32'hDEADBEEF);
    vecs[1]  = mk(1, 0, 32'h1234,     0, 0, 0, 0,        0, 0, 0, 0);
    vecs[2]  = mk(1, 5, 32'd7,        1, 0, 0, 0,        0, 1, 5, 32'd7);
    vecs[3]  = mk(0, 0, 0,            0, 0, 0, 0,        0, 1, 5, 32'd1);
    vecs[4]  = mk(0, 0, 0,            0, 1, 10, 32'h55,  1, 1, 10, 32'h55);
    vecs[5]  = mk(0, 0, 0,            0, 1, 0, 32'h99,   1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0,            1, 1, 12, 32'h66,  0, 1, 5, 32'd1);
    vecs[7]  = mk(0, 0, 0,            0, 1, 12, 32'h66,  1, 1, 12, 32'h66);
    vecs[8]  = mk(1, 7, 32'hA5A5,     0, 1, 13, 32'h13,  0, 1, 7, 32'hA5A5);
    vecs[9]  = mk(0, 0, 0,            0, 1, 13, 32'h13,  1, 1, 13, 32'h13);
    vecs[10] = mk(1, 0, 32'hFF,       1, 0, 0, 0,        0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0,            0, 1, 14, 32'h44,  0, 1, 5, 32'd1);
    vecs[12] = mk(0, 0, 0,            0, 1, 14, 32'h44,  1, 1, 14, 32'h44);
    vecs[13] = mk(0, 0, 0,            0, 0, 0, 0,        0, 0, 0, 0);

    foreach (vecs[n]) begin
      bus.core_we   = vecs[n].cwe;
      bus.core_addr = vecs[n].caddr;
      bus.core_data = vecs[n].cdata;
      bus.trigger   = vecs[n].trig;
      bus.dbg_valid = vecs[n].dv;
      bus.dbg_addr  = vecs[n].daddr;
      bus.dbg_data  = vecs[n].ddata;
      #1 chk($sformatf("vec%0d_rdy", n), bus.dbg_ready, vecs[n].e_rdy);
      step();
      chk($sformatf("vec%0d_we", n), bus.rf_we, vecs[n].e_we);
      if (vecs[n].e_we)
        chk($sformatf("vec%0d_wr", n), {bus.rf_addr, bus.rf_wd}, {vecs[n].e_addr, vecs[n].e_wd});
    end
    idle();

    // Starvation: core keeps writing, debug blocked, stall after LIM blocked cycles
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = AW'(10);
    bus.dbg_data  = 32'h55;
    bus.core_we   = 1'b1;
    bus.core_addr = AW'(20);
    for (int k = 1; k <= LIM + 2; k++) begin
      bus.core_data = 32'(100 + k);
      #1 chk("starve_rdy", bus.dbg_ready, 0);
      step();
      chk("starve_core_wd", {bus.rf_we, bus.rf_addr, bus.rf_wd}, {1'b1, AW'(20), 32'(100 + k)});
      chk($sformatf("starve_stall_k%0d", k), bus.core_stall, (k >= LIM));
    end
    bus.core_we = 1'b0;
    #1 chk("starve_grant_rdy", bus.dbg_ready, 1);
    step();
    chk("starve_grant_wr", {bus.rf_we, bus.rf_addr, bus.rf_wd}, {1'b1, AW'(10), 32'h55});
    chk("starve_stall_release", bus.core_stall, 0);
    idle();
    step();
    chk("starve_idle_we", bus.rf_we, 0);

    // Mid-RUN reset with a blocked debug request and a pending trigger
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = AW'(11);
    bus.dbg_data  = 32'h77;
    bus.core_we   = 1'b1;
    bus.core_addr = AW'(6);
    bus.core_data = 32'h6;
    bus.trigger   = 1'b1;
    step();
    bus.trigger = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    bus.core_we = 1'b0;
    #1;
    chk("mrst_we", bus.rf_we, 0);
    chk("mrst_addr", bus.rf_addr, 0);
    chk("mrst_wd", bus.rf_wd, 0);
    chk("mrst_busy", bus.clear_busy, 1);
    chk("mrst_stall", bus.core_stall, 1);
    chk("mrst_dbg_ready", bus.dbg_ready, 0);
    step();
    step();
    chk("mrst_hold_ready", bus.dbg_ready, 0);
    idle();
    rst_n = 1'b1;
    check_clear(1'b0);
    step();
    chk("mrst_no_stale_write", bus.rf_we, 0);

    // Random traffic against a reference model of the arbitration rules
    begin
      bit            pend     = 1'b0;
      bit            dbg_hold = 1'b0;
      int            blocked  = 0;
      int            m_acc    = 0;
      int            d_acc    = 0;
      bit            m_rdy;
      bit            has_wr;
      bit            e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      for (int r = 0; r < NREG; r++) begin
        mrf[r] = '0;
        drf[r] = '0;
      end
      for (int c = 0; c < 2000; c++) begin
        bus.core_we   = ($urandom_range(0, 99) < 45);
        bus.core_addr = AW'($urandom_range(0, NREG - 1));
        bus.core_data = $urandom();
        bus.trigger   = ($urandom_range(0, 99) < 12);
        if (!dbg_hold) begin
          bus.dbg_valid = ($urandom_range(0, 99) < 40);
          bus.dbg_addr  = AW'($urandom_range(0, NREG - 1));
          bus.dbg_data  = $urandom();
        end
        m_rdy  = 1'b0;
        has_wr = 1'b0;
        e_addr = '0;
        e_wd   = '0;
        if (bus.core_we) begin
          has_wr = 1'b1;
          e_addr = bus.core_addr;
          e_wd   = bus.core_data;
          pend   = pend | bus.trigger;
        end else if (pend || bus.trigger) begin
          has_wr = 1'b1;
          e_addr = AW'(TRIG);
          e_wd   = 32'd1;
          pend   = 1'b0;
        end else if (bus.dbg_valid) begin
          has_wr = 1'b1;
          m_rdy  = 1'b1;
          e_addr = bus.dbg_addr;
          e_wd   = bus.dbg_data;
          m_acc++;
        end
        e_we    = has_wr && (e_addr != '0);
        blocked = (bus.dbg_valid && !m_rdy) ? ((blocked < LIM) ? blocked + 1 : LIM) : 0;
        #1 chk("rnd_rdy", bus.dbg_ready, m_rdy);
        if (bus.dbg_valid && bus.dbg_ready) d_acc++;
        dbg_hold = bus.dbg_valid && !m_rdy;
        step();
        chk("rnd_we", bus.rf_we, e_we);
        if (e_we) chk("rnd_wr", {bus.rf_addr, bus.rf_wd}, {e_addr, e_wd});
        chk("rnd_stall", bus.core_stall, (blocked == LIM));
        if (e_we) mrf[e_addr] = e_wd;
        if (bus.rf_we) drf[bus.rf_addr] = bus.rf_wd;
      end
      idle();
      chk("rnd_dbg_accepts", d_acc, m_acc);
      for (int r = 0; r < NREG; r++)
        chk($sformatf("rnd_regfile_x%0d", r), drf[r], mrf[r]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
